// File: rtl/sd_frame_wr_sched.sv
// SD-card frame write scheduler: arms on a capture request, aligns to the
// next frame start, gates the FIFO writer and issues one write start per
// buffered sector while tracking sector address/count and faults.
//
// Ports:
//   clk_ref, rst_n         clock, async active-low reset
//   sd_init_done           SD card ready (level); low aborts a capture
//   capture_req            one-cycle request to capture a frame
//   frame_sof              one-cycle start of frame
//   fifo_rdusedw           words buffered on the FIFO read side
//   fifo_wrfull            FIFO full (overflow while gated sets err)
//   wr_busy                SD controller write busy
//   wr_start_en            one-cycle sector write start
//   wr_sec_addr            sector address of the current write
//   fifo_wr_gate           FIFO writer enable
//   capturing              capture in progress
//   done                   frame fully written (sticky)
//   err                    sticky fault flag
//   sec_cnt                sectors completed in this capture
module sd_frame_wr_sched #(
    parameter logic [31:0] START_ADDR        = 32'd20000,
    parameter logic [11:0] SECTORS_PER_FRAME = 12'd3072,
    parameter logic [9:0]  WORDS_PER_SEC     = 10'd256,
    parameter logic [7:0]  BUSY_TIMEOUT      = 8'd64
) (
    input  logic        clk_ref,
    input  logic        rst_n,
    input  logic        sd_init_done,
    input  logic        capture_req,
    input  logic        frame_sof,
    input  logic [9:0]  fifo_rdusedw,
    input  logic        fifo_wrfull,
    input  logic        wr_busy,
    output logic        wr_start_en,
    output logic [31:0] wr_sec_addr,
    output logic        fifo_wr_gate,
    output logic        capturing,
    output logic        done,
    output logic        err,
    output logic [11:0] sec_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FILL,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        gate_q, gate_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic        cap_q, cap_d;
    logic        busy_q;
    logic        busy_fall;

    assign busy_fall = busy_q && !wr_busy;

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= START_ADDR;
            cnt_q   <= '0;
            tmo_q   <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            cap_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            cap_q   <= cap_d;
            busy_q  <= wr_busy;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        gate_d  = gate_q;
        done_d  = done_q;
        err_d   = err_q;

        // FIFO overflow while gated is flagged but the capture carries on
        if (gate_q && fifo_wrfull)
            err_d = 1'b1;

        if (state_q != S_IDLE && !sd_init_done) begin
            // card lost mid-capture: abort without reporting completion
            err_d   = 1'b1;
            gate_d  = 1'b0;
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (capture_req && sd_init_done) begin
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        addr_d  = START_ADDR;
                        state_d = S_ARM;
                    end
                end
                S_ARM: begin
                    if (frame_sof) begin
                        gate_d  = 1'b1;
                        state_d = S_FILL;
                    end
                end
                S_FILL: begin
                    if (fifo_rdusedw >= WORDS_PER_SEC)
                        state_d = S_START;
                end
                S_START: begin
                    tmo_d   = '0;
                    state_d = S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (wr_busy) begin
                        state_d = S_WAIT_LO;
                    end else if (tmo_q == BUSY_TIMEOUT - 8'd1) begin
                        // no response: flag it and retry the same sector
                        err_d   = 1'b1;
                        state_d = S_START;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
                S_WAIT_LO: begin
                    if (busy_fall) begin
                        cnt_d  = cnt_q + 12'd1;
                        addr_d = addr_q + 32'd1;
                        if (cnt_q + 12'd1 == SECTORS_PER_FRAME)
                            state_d = S_FIN;
                        else
                            state_d = S_FILL;
                    end
                end
                S_FIN: begin
                    gate_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // registered so the pulse coincides with the START state
        start_d = (state_d == S_START);
        cap_d   = (state_d != S_IDLE);
    end

    assign wr_start_en  = start_q;
    assign wr_sec_addr  = addr_q;
    assign fifo_wr_gate = gate_q;
    assign capturing    = cap_q;
    assign done         = done_q;
    assign err          = err_q;
    assign sec_cnt      = cnt_q;

endmodule

// File: tb/tb_sd_frame_wr_sched.sv
// Testbench for sd_frame_wr_sched: cycle-accurate vector table plus
// directed sequences for reset, busy timeout and abort/overflow cases.
module tb_sd_frame_wr_sched;

    logic        clk_ref = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_init_done = 1'b1;
    logic        capture_req = 1'b0;
    logic        frame_sof = 1'b0;
    logic [9:0]  fifo_rdusedw = '0;
    logic        fifo_wrfull = 1'b0;
    logic        wr_busy = 1'b0;
    logic        wr_start_en;
    logic [31:0] wr_sec_addr;
    logic        fifo_wr_gate;
    logic        capturing;
    logic        done;
    logic        err;
    logic [11:0] sec_cnt;

    int errors = 0;
    int checks = 0;

    sd_frame_wr_sched #(
        .START_ADDR       (32'd20000),
        .SECTORS_PER_FRAME(12'd3),
        .WORDS_PER_SEC    (10'd256),
        .BUSY_TIMEOUT     (8'd64)
    ) dut (
        .clk_ref     (clk_ref),
        .rst_n       (rst_n),
        .sd_init_done(sd_init_done),
        .capture_req (capture_req),
        .frame_sof   (frame_sof),
        .fifo_rdusedw(fifo_rdusedw),
        .fifo_wrfull (fifo_wrfull),
        .wr_busy     (wr_busy),
        .wr_start_en (wr_start_en),
        .wr_sec_addr (wr_sec_addr),
        .fifo_wr_gate(fifo_wr_gate),
        .capturing   (capturing),
        .done        (done),
        .err         (err),
        .sec_cnt     (sec_cnt)
    );

    always #5 clk_ref = ~clk_ref;

    typedef struct {
        logic        req;
        logic        sd;
        logic        sof;
        logic [9:0]  rd;
        logic        busy;
        logic        full;
        logic        st;
        logic [31:0] addr;
        logic        gate;
        logic        cap;
        logic        dn;
        logic        er;
        logic [11:0] cnt;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(
        input logic req, input logic sd, input logic sof,
        input logic [9:0] rd, input logic busy, input logic full,
        input logic st, input logic [31:0] addr, input logic gate,
        input logic cap, input logic dn, input logic er,
        input logic [11:0] cnt);
        vec_t v;
        v.req = req; v.sd = sd; v.sof = sof; v.rd = rd;
        v.busy = busy; v.full = full; v.st = st; v.addr = addr;
        v.gate = gate; v.cap = cap; v.dn = dn; v.er = er;
        v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!wr_start_en && n < 300) begin
            cyc();
            n++;
        end
        chk("start_seen", {31'd0, wr_start_en}, 32'd1);
    endtask

    task automatic serve(input int lat, input logic [31:0] exp_addr);
        int n;
        wait_start(n);
        chk("serve_addr", wr_sec_addr, exp_addr);
        repeat (lat) cyc();
        wr_busy = 1'b1;
        cyc();
        cyc();
        wr_busy = 1'b0;
        cyc();
    endtask

    task automatic start_cap();
        capture_req = 1'b1;
        cyc();
        capture_req = 1'b0;
        chk("accept_done_clr", {31'd0, done}, 32'd0);
        chk("accept_err_clr", {31'd0, err}, 32'd0);
        chk("accept_cnt_clr", {20'd0, sec_cnt}, 32'd0);
        frame_sof = 1'b1;
        cyc();
        frame_sof = 1'b0;
        chk("gate_on", {31'd0, fifo_wr_gate}, 32'd1);
    endtask

    initial begin
        int n;
        // req sd sof rd busy full | st addr gate cap done err cnt
        tbl[0]  = mk(0,1,0,10'd0,  0,0, 0,20000,0,0,0,0,12'd0);
        tbl[1]  = mk(1,0,0,10'd0,  0,0, 0,20000,0,0,0,0,12'd0);
        tbl[2]  = mk(1,1,0,10'd0,  0,0, 0,20000,0,1,0,0,12'd0);
        tbl[3]  = mk(0,1,0,10'd0,  0,1, 0,20000,0,1,0,0,12'd0);
        tbl[4]  = mk(0,1,1,10'd0,  0,0, 0,20000,1,1,0,0,12'd0);
        tbl[5]  = mk(0,1,0,10'd255,0,0, 0,20000,1,1,0,0,12'd0);
        tbl[6]  = mk(0,1,0,10'd255,0,0, 0,20000,1,1,0,0,12'd0);
        tbl[7]  = mk(0,1,0,10'd256,0,0, 1,20000,1,1,0,0,12'd0);
        tbl[8]  = mk(0,1,0,10'd0,  0,0, 0,20000,1,1,0,0,12'd0);
        tbl[9]  = mk(0,1,0,10'd0,  1,0, 0,20000,1,1,0,0,12'd0);
        tbl[10] = mk(1,1,0,10'd0,  1,0, 0,20000,1,1,0,0,12'd0);
        tbl[11] = mk(0,1,0,10'd0,  0,0, 0,20001,1,1,0,0,12'd1);
        tbl[12] = mk(0,1,0,10'd256,0,0, 1,20001,1,1,0,0,12'd1);
        tbl[13] = mk(0,1,0,10'd256,1,0, 0,20001,1,1,0,0,12'd1);
        tbl[14] = mk(0,1,0,10'd256,1,0, 0,20001,1,1,0,0,12'd1);
        tbl[15] = mk(0,1,0,10'd256,0,0, 0,20002,1,1,0,0,12'd2);
        tbl[16] = mk(0,1,0,10'd256,0,0, 1,20002,1,1,0,0,12'd2);
        tbl[17] = mk(0,1,0,10'd0,  1,0, 0,20002,1,1,0,0,12'd2);
        tbl[18] = mk(0,1,0,10'd0,  1,0, 0,20002,1,1,0,0,12'd2);
        tbl[19] = mk(0,1,0,10'd0,  0,0, 0,20003,1,1,0,0,12'd3);
        tbl[20] = mk(0,1,0,10'd0,  0,0, 0,20003,0,0,1,0,12'd3);
        tbl[21] = mk(0,1,0,10'd0,  0,1, 0,20003,0,0,1,0,12'd3);

        // reset values
        #12;
        chk("rst_start", {31'd0, wr_start_en}, 32'd0);
        chk("rst_addr", wr_sec_addr, 32'd20000);
        chk("rst_gate", {31'd0, fifo_wr_gate}, 32'd0);
        chk("rst_cap", {31'd0, capturing}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", {20'd0, sec_cnt}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // cycle-accurate table
        for (int i = 0; i < 22; i++) begin
            capture_req  = tbl[i].req;
            sd_init_done = tbl[i].sd;
            frame_sof    = tbl[i].sof;
            fifo_rdusedw = tbl[i].rd;
            wr_busy      = tbl[i].busy;
            fifo_wrfull  = tbl[i].full;
            cyc();
            chk($sformatf("v%0d_start", i),
                {31'd0, wr_start_en}, {31'd0, tbl[i].st});
            chk($sformatf("v%0d_addr", i), wr_sec_addr, tbl[i].addr);
            chk($sformatf("v%0d_gate", i),
                {31'd0, fifo_wr_gate}, {31'd0, tbl[i].gate});
            chk($sformatf("v%0d_cap", i),
                {31'd0, capturing}, {31'd0, tbl[i].cap});
            chk($sformatf("v%0d_done", i),
                {31'd0, done}, {31'd0, tbl[i].dn});
            chk($sformatf("v%0d_err", i),
                {31'd0, err}, {31'd0, tbl[i].er});
            chk($sformatf("v%0d_cnt", i),
                {20'd0, sec_cnt}, {20'd0, tbl[i].cnt});
        end
        capture_req = 1'b0;
        fifo_wrfull = 1'b0;
        wr_busy = 1'b0;
        fifo_rdusedw = '0;

        // reset asserted while waiting for the busy fall
        start_cap();
        fifo_rdusedw = 10'd256;
        wait_start(n);
        chk("a_addr", wr_sec_addr, 32'd20000);
        wr_busy = 1'b1;
        cyc();
        cyc();
        chk("a_cap_pre", {31'd0, capturing}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_rst_start", {31'd0, wr_start_en}, 32'd0);
        chk("a_rst_addr", wr_sec_addr, 32'd20000);
        chk("a_rst_gate", {31'd0, fifo_wr_gate}, 32'd0);
        chk("a_rst_cap", {31'd0, capturing}, 32'd0);
        chk("a_rst_cnt", {20'd0, sec_cnt}, 32'd0);
        wr_busy = 1'b0;
        fifo_rdusedw = '0;
        #1;
        rst_n = 1'b1;
        cyc();

        // busy never rises: timeout, retry at same address, then complete
        start_cap();
        fifo_rdusedw = 10'd256;
        wait_start(n);
        chk("b_addr0", wr_sec_addr, 32'd20000);
        cyc();
        chk("b_err_pre", {31'd0, err}, 32'd0);
        wait_start(n);
        chk("b_retry_gap", n, 32'd64);
        chk("b_err", {31'd0, err}, 32'd1);
        chk("b_retry_addr", wr_sec_addr, 32'd20000);
        serve(10, 32'd20000);
        serve(10, 32'd20001);
        serve(10, 32'd20002);
        fifo_rdusedw = '0;
        repeat (3) cyc();
        chk("b_done", {31'd0, done}, 32'd1);
        chk("b_err_hold", {31'd0, err}, 32'd1);
        chk("b_cnt", {20'd0, sec_cnt}, 32'd3);
        chk("b_gate", {31'd0, fifo_wr_gate}, 32'd0);
        chk("b_cap", {31'd0, capturing}, 32'd0);
        chk("b_addr_end", wr_sec_addr, 32'd20003);

        // overflow while gated, then card drop during FILL
        start_cap();
        fifo_wrfull = 1'b1;
        cyc();
        fifo_wrfull = 1'b0;
        chk("c_ovf_err", {31'd0, err}, 32'd1);
        chk("c_ovf_cap", {31'd0, capturing}, 32'd1);
        sd_init_done = 1'b0;
        cyc();
        chk("c_abort_cap", {31'd0, capturing}, 32'd0);
        chk("c_abort_gate", {31'd0, fifo_wr_gate}, 32'd0);
        chk("c_abort_err", {31'd0, err}, 32'd1);
        chk("c_abort_done", {31'd0, done}, 32'd0);
        sd_init_done = 1'b1;
        fifo_rdusedw = 10'd256;
        repeat (3) cyc();
        chk("c_idle_start", {31'd0, wr_start_en}, 32'd0);
        chk("c_idle_cap", {31'd0, capturing}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_frame_wr_sched.md
# sd_frame_wr_sched

Sequencing controller for the SD-card write path of the frame-capture chain. It arms on a capture request and aligns to the next frame start. It gates pixel words into the write FIFO and issues one `wr_start_en` pulse to the SD controller per 256 buffered words (one 512-byte sector). It tracks the sector address and count, detects handshake faults and reports completion. It sits between the capture FIFO (read side, `clk_ref` domain) and `sd_ctrl_top`'s user write port.

## Interface
- `START_ADDR`, 32'd20000: first sector address of the frame image.
- `SECTORS_PER_FRAME`, 12'd3072: number of sectors per capture; legal range 1..4095.
- `WORDS_PER_SEC`, 10'd256: 16-bit words per sector.
- `BUSY_TIMEOUT`, 8'd64: cycles allowed between the `wr_start_en` pulse and the `wr_busy` rise.
- `clk_ref`  in  1  system/SD controller clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sd_init_done`  in  1  SD card initialised (level).
- `capture_req`  in  1  single-cycle request to capture one frame (debounced button).
- `frame_sof`  in  1  single-cycle start-of-frame, already synchronised to `clk_ref`.
- `fifo_rdusedw`  in  10  words available on the FIFO read side.
- `fifo_wrfull`  in  1  FIFO full, synchronised to `clk_ref`.
- `wr_busy`  in  1  SD controller write busy.
- `wr_start_en`  out  1  one-cycle sector write start.
- `wr_sec_addr`  out  32  sector address for the current write.
- `fifo_wr_gate`  out  1  enable for the FIFO writer (integrator synchronises it into `hdmi_clk`).
- `capturing`  out  1  capture in progress.
- `done`  out  1  frame fully written (sticky until the next accepted request).
- `err`  out  1  sticky fault flag.
- `sec_cnt`  out  12  sectors completed in the current capture.

## Operation
- States: IDLE, ARM, FILL, START, WAIT_HI, WAIT_LO, FIN.
- IDLE: on `capture_req` && `sd_init_done`:
  - clear `done`, `err` and `sec_cnt`;
  - load `wr_sec_addr`=START_ADDR;
  - go to ARM.
  - `capture_req` with `sd_init_done`=0 is ignored.
- ARM: wait for `frame_sof`. On `frame_sof`, set `fifo_wr_gate`=1 and go to FILL.
- FILL: when `fifo_rdusedw` >= WORDS_PER_SEC, go to START.
- START: `wr_start_en`=1 for exactly this cycle; clear the timeout counter; go to WAIT_HI.
- WAIT_HI:
  - `wr_busy`=1 → go to WAIT_LO.
  - Counter reaches BUSY_TIMEOUT → set `err` and go back to START, which re-issues the pulse at the same address.
- WAIT_LO: on the `wr_busy` falling edge (registered previous value 1, current value 0):
  - increment `sec_cnt`;
  - increment `wr_sec_addr`;
  - if the new `sec_cnt` == SECTORS_PER_FRAME, go to FIN; otherwise go to FILL.
- FIN: `fifo_wr_gate`=0 and `done`=1, then go to IDLE on the next cycle. `done` holds until the next accepted `capture_req`.
- `capturing`=1 in every state except IDLE.
- `capture_req` while capturing is ignored.
- `fifo_wrfull`=1 while `fifo_wr_gate`=1 sets `err` (overflow). The capture still proceeds.
- `sd_init_done` falling in any non-IDLE state aborts the capture:
  - set `err`;
  - drop `fifo_wr_gate`;
  - go to IDLE;
  - `done` stays 0.
- Arithmetic: `sec_cnt` is 12-bit. `wr_sec_addr` is 32-bit and wraps modulo 2^32 with no flag.

## Timing
- All outputs are registered.
- Reset values: `wr_start_en`=0, `wr_sec_addr`=START_ADDR, `fifo_wr_gate`=0, `capturing`=0, `done`=0, `err`=0, `sec_cnt`=0, state=IDLE, registered busy=0.
- The FILL threshold is evaluated on the cycle it is met; `wr_start_en` rises 1 cycle later.
- `wr_sec_addr` is stable from 1 cycle before `wr_start_en` until the `wr_busy` fall.
- `wr_sec_addr` and `sec_cnt` update 1 cycle after the `wr_busy` falling edge is sampled.
- Minimum spacing between consecutive `wr_start_en` pulses is 4 cycles (START, WAIT_HI, WAIT_LO, FILL).
- `done` rises 1 cycle after the final `sec_cnt` update.
- A busy pulse shorter than 1 cycle is not supported.
- `wr_busy` already high on entry to WAIT_HI counts as the rise.

## Test plan
- Reset mid-WAIT_LO → all outputs return to reset values immediately; the next `capture_req` starts again at address 20000.
- SECTORS_PER_FRAME=3, FIFO model refilled instantly, `wr_busy` high 10 cycles after each start → 3 `wr_start_en` pulses at addresses 20000, 20001, 20002; then `done`=1, `sec_cnt`=3, `fifo_wr_gate`=0.
- `fifo_rdusedw` held at 255 → no `wr_start_en`; step it to 256 → exactly one pulse 1 cycle later.
- `wr_busy` never rises → `err`=1 after 64 cycles and `wr_start_en` is re-pulsed at 20000; `wr_busy` then responds → capture completes with `err` still 1.
- `capture_req` while `sd_init_done`=0 → stays in IDLE. `sd_init_done` dropped during FILL → IDLE, `err`=1, `done`=0, `fifo_wr_gate`=0.
- `fifo_wrfull` pulsed while gated → `err`=1. `capture_req` mid-capture → ignored, address sequence unchanged.
